// File: rtl/alto_control_sequencer.sv
// Alto-style microprogram sequencer: per-task saved micro-PC file, priority
// task switching on TASK, boot-time MPC initialisation sweep and a reset-mode
// register that picks the start bank of every task.
//
// state | meaning
// INIT  | sweep writes the init value of task idx each cycle; mpc_o held at 0
// RUN   | normal sequencing of the current task from mpc_q
module alto_control_sequencer #(
  parameter int TASKS  = 16,
  parameter int TASK_W = 4,
  parameter int MPC_W  = 12,
  parameter int NEXT_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [TASKS-1:0]  task_request_i,
  input  logic              switch_task_i,
  input  logic [NEXT_W-1:0] next_addr_i,
  input  logic [NEXT_W-1:0] modifier_i,
  input  logic              stall_i,
  input  logic              rmr_load_i,
  input  logic [TASKS-1:0]  rmr_data_i,
  input  logic              boot_i,
  output logic [MPC_W-1:0]  mpc_o,
  output logic [TASK_W-1:0] current_task_o,
  output logic              initializing_o,
  output logic              task_switched_o
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  localparam logic [TASK_W-1:0] LAST_IDX = TASK_W'(TASKS - 1);

  state_e            state_q, state_d;
  logic [TASK_W-1:0] idx_q, idx_d;
  logic [TASK_W-1:0] task_q, task_d;
  logic [MPC_W-1:0]  mpc_q, mpc_d;
  logic [TASKS-1:0]  rmr_q, rmr_d;
  logic              switched_q, switched_d;

  logic [MPC_W-1:0]  mpc_file_q [TASKS];
  logic              file_we;
  logic [TASK_W-1:0] file_waddr;
  logic [MPC_W-1:0]  file_wdata;

  logic [MPC_W-1:0]  na;
  logic [TASK_W-1:0] nt;

  // Task 0 always requests, so its request line carries no information.
  logic unused_req0;
  assign unused_req0 = task_request_i[0];

  // Bank 0 when the RMR bit is set, otherwise bank 1 (bit NEXT_W).
  function automatic logic [MPC_W-1:0] init_value(input logic [TASK_W-1:0] t,
                                                   input logic [TASKS-1:0]  rmr);
    logic [MPC_W-1:0] v;
    v = MPC_W'(t);
    if (!rmr[t]) v[NEXT_W] = 1'b1;
    return v;
  endfunction

  // In-page branch target: page bits of the current address are kept.
  assign na = {mpc_q[MPC_W-1:NEXT_W], next_addr_i | modifier_i};

  // Highest-numbered requesting task; falls back to the emulator (task 0).
  always_comb begin
    nt = '0;
    for (int t = 1; t < TASKS; t++) begin
      if (task_request_i[t]) nt = TASK_W'(t);
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  // Next-state logic: boot always restarts the sweep.
  always_comb begin
    state_d = state_q;
    if (boot_i)                                        state_d = ST_INIT;
    else if (state_q == ST_INIT && idx_q == LAST_IDX)  state_d = ST_RUN;
  end

  // Output decode.
  always_comb begin
    initializing_o = (state_q == ST_INIT);
    mpc_o          = (state_q == ST_INIT) ? '0 : mpc_q;
  end

  assign current_task_o  = task_q;
  assign task_switched_o = switched_q;

  // Datapath next values: sweep, advance, switch and stall handling.
  always_comb begin
    idx_d      = idx_q;
    task_d     = task_q;
    mpc_d      = mpc_q;
    rmr_d      = rmr_q;
    switched_d = 1'b0;
    file_we    = 1'b0;
    file_waddr = task_q;
    file_wdata = na;

    if (rmr_load_i) rmr_d = rmr_data_i;

    if (state_q == ST_INIT) begin
      file_we    = 1'b1;
      file_waddr = idx_q;
      file_wdata = init_value(idx_q, rmr_q);
    end

    if (boot_i) begin
      idx_d = '0;
    end else if (state_q == ST_INIT) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == LAST_IDX) begin
        idx_d  = '0;
        task_d = '0;
        mpc_d  = init_value('0, rmr_q);
      end
    end else if (!stall_i) begin
      file_we    = 1'b1;
      file_waddr = task_q;
      file_wdata = na;
      mpc_d      = na;
      if (switch_task_i) begin
        task_d = nt;
        // Same-task switch keeps na: the file write above lands too late to read.
        if (nt != task_q) begin
          mpc_d      = mpc_file_q[nt];
          switched_d = 1'b1;
        end
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q      <= '0;
      task_q     <= '0;
      mpc_q      <= '0;
      rmr_q      <= '1;
      switched_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      task_q     <= task_d;
      mpc_q      <= mpc_d;
      rmr_q      <= rmr_d;
      switched_q <= switched_d;
    end
  end

  // Saved-MPC file; contents are meaningless until the first sweep completes.
  always_ff @(posedge clk_i) begin
    if (file_we) mpc_file_q[file_waddr] <= file_wdata;
  end

endmodule
